// File: rtl/spi_xfer_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// spi_xfer_arbiter_pkg
// Shared definitions for the SPI transfer arbiter: SPI core width defaults and
// the arbiter state encoding.
// Ports: none (package).
// -----------------------------------------------------------------------------
package spi_xfer_arbiter_pkg;

  localparam int SPI_MAX_CHAR = 128;  // widest character the SPI master shifts
  localparam int SPI_SS_W     = 3;    // slave index width; master has 2**SPI_SS_W selects

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_LOAD = 3'd2,
    ST_WAIT = 3'd3,
    ST_RESP = 3'd4,
    ST_GAP  = 3'd5
  } arb_state_e;

endpackage

// File: rtl/spi_xfer_arbiter_rr.sv
// -----------------------------------------------------------------------------
// spi_xfer_arbiter_rr
// Combinational round-robin pick: grants the first set request at or after
// the pointer, wrapping past NREQ-1 back to 0.
// Ports:
//   req  in  NREQ  request vector
//   ptr  in  PW    index with highest priority this round
//   gnt  out NREQ  one-hot grant, all zero when req is zero
// -----------------------------------------------------------------------------
module spi_xfer_arbiter_rr
  import spi_xfer_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// -----------------------------------------------------------------------------
// spi_xfer_arbiter
// Shares one SPI master core among NREQ requesters. A round-robin pick loads
// the winner's slave select, char length and TX word into the master, pulses
// go, waits for the busy falling edge and returns RX data with a one-cycle ack.
// Optional transfer watchdog: define SPI_ARB_TIMEOUT_EN. When undefined there
// is no counter, err_o is tied low and WAIT waits indefinitely.
// Ports:
//   wb_clk_i    in   system clock, rising edge
//   wb_rst_n_i  in   asynchronous reset, active low
//   req_i       in   per-requester request, held until its ack
//   req_ss_i    in   per-requester slave index (SSW each)
//   req_len_i   in   per-requester char length (LENW each, 0 = DW bits)
//   req_tx_i    in   per-requester TX word (DW each)
//   ack_o       out  one-hot one-cycle completion pulse
//   err_o       out  watchdog abort flag, valid with ack_o
//   rx_o        out  RX word, valid in the ack_o cycle
//   m_go_o      out  one-cycle start pulse to the master
//   m_ss_o      out  one-hot active-high slave select to the master
//   m_len_o     out  char length to the master
//   m_tx_o      out  TX word to the master
//   m_busy_i    in   master transfer in progress
//   m_rx_i      in   master RX shift register
//
// state | meaning
// IDLE  | no transfer, waiting for any request
// ARB   | pick winner, register its ss/len/tx; back to IDLE if requests vanished
// LOAD  | m_go_o high for this single cycle
// WAIT  | transfer running; leave on busy falling edge (or watchdog)
// RESP  | capture RX, pulse ack, advance pointer, deselect slave
// GAP   | GAP_CYC cycles with no slave selected
// -----------------------------------------------------------------------------
module spi_xfer_arbiter
  import spi_xfer_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = SPI_MAX_CHAR,
  parameter int LENW    = 7,
  parameter int SSW     = SPI_SS_W,
  parameter int GAP_CYC = 2,
  parameter int TO_CYC  = 4096
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*SSW-1:0]  req_ss_i,
  input  logic [NREQ*LENW-1:0] req_len_i,
  input  logic [NREQ*DW-1:0]   req_tx_i,
  output logic [NREQ-1:0]      ack_o,
  output logic                 err_o,
  output logic [DW-1:0]        rx_o,
  output logic                 m_go_o,
  output logic [(2**SSW)-1:0]  m_ss_o,
  output logic [LENW-1:0]      m_len_o,
  output logic [DW-1:0]        m_tx_o,
  input  logic                 m_busy_i,
  input  logic [DW-1:0]        m_rx_i
);

  localparam int SSNB = 2**SSW;
  localparam int PW   = $clog2(NREQ);
  localparam int GCW  = $clog2(GAP_CYC + 1);

  if (NREQ < 2 || NREQ > 8 || GAP_CYC < 1 || TO_CYC < 2) begin : g_bad_param
    $error("spi_xfer_arbiter: parameter out of range");
  end

  arb_state_e      state, state_nx;
  logic [PW-1:0]   rr_ptr;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] gnt_q;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   gnt_idx;
  logic [SSW-1:0]  ss_win;
  logic [SSNB-1:0] ss_dec;
  logic            busy_seen;
  logic            xfer_done;
  logic            to_expire;
  logic            to_flag;
  logic [GCW-1:0]  gap_cnt;

  spi_xfer_arbiter_rr #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req (req_i),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) win_idx = PW'(i);
    end
  end

  assign ss_win    = req_ss_i[win_idx*SSW +: SSW];
  assign ss_dec    = {{(SSNB-1){1'b0}}, 1'b1} << ss_win;
  // Falling edge of busy, once the master has actually started.
  assign xfer_done = busy_seen && !m_busy_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state <= ST_IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    m_go_o   = 1'b0;
    case (state)
      ST_IDLE: if (|req_i) state_nx = ST_ARB;
      ST_ARB:  state_nx = (|req_i) ? ST_LOAD : ST_IDLE;
      ST_LOAD: begin
        m_go_o   = 1'b1;
        state_nx = ST_WAIT;
      end
      ST_WAIT: if (xfer_done || to_expire) state_nx = ST_RESP;
      ST_RESP: state_nx = ST_GAP;
      ST_GAP:  if (gap_cnt == '0) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rr_ptr    <= '0;
      gnt_q     <= '0;
      gnt_idx   <= '0;
      busy_seen <= 1'b0;
      gap_cnt   <= '0;
      ack_o     <= '0;
      rx_o      <= '0;
      m_ss_o    <= '0;
      m_len_o   <= '0;
      m_tx_o    <= '0;
    end else begin
      ack_o <= '0;
      case (state)
        ST_ARB: begin
          if (|req_i) begin
            gnt_q   <= gnt;
            gnt_idx <= win_idx;
            m_ss_o  <= ss_dec;
            m_len_o <= req_len_i[win_idx*LENW +: LENW];
            m_tx_o  <= req_tx_i[win_idx*DW +: DW];
          end
        end
        // A master that raises busy in the go cycle still counts as started.
        ST_LOAD: busy_seen <= m_busy_i;
        ST_WAIT: if (m_busy_i) busy_seen <= 1'b1;
        ST_RESP: begin
          ack_o   <= gnt_q;
          rx_o    <= to_flag ? '0 : m_rx_i;
          rr_ptr  <= (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
          m_ss_o  <= '0;
          gap_cnt <= GCW'(GAP_CYC - 1);
        end
        ST_GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TCW = $clog2(TO_CYC + 1);

  logic [TCW-1:0] to_cnt;

  // Counts LOAD+WAIT cycles; the TO_CYC-th one forces RESP.
  assign to_expire = (state == ST_WAIT) && (to_cnt == TCW'(TO_CYC - 1));

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      case (state)
        ST_ARB: begin
          to_cnt  <= '0;
          to_flag <= 1'b0;
        end
        ST_LOAD: to_cnt <= to_cnt + 1'b1;
        ST_WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          if (to_expire && !xfer_done) to_flag <= 1'b1;
        end
        ST_RESP: err_o <= to_flag;
        default: ;
      endcase
    end
  end
`else
  assign to_expire = 1'b0;
  assign to_flag   = 1'b0;
  assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
module tb_spi_xfer_arbiter;

  localparam int NREQ = 4, DW = 128, LENW = 7, SSW = 3, GAP_CYC = 2, TO_CYC = 64;
  localparam int BUSY_CYC = 16;
  // LOAD at L, busy high L+1..L+16, seen low at L+17, RESP L+18, ack L+19
  localparam int ACK_LAT = BUSY_CYC + 3;

  logic                 clk, rst_n;
  logic [NREQ-1:0]      req_i;
  logic [NREQ*SSW-1:0]  req_ss_i;
  logic [NREQ*LENW-1:0] req_len_i;
  logic [NREQ*DW-1:0]   req_tx_i;
  logic [NREQ-1:0]      ack_o;
  logic                 err_o;
  logic [DW-1:0]        rx_o;
  logic                 m_go_o;
  logic [7:0]           m_ss_o;
  logic [LENW-1:0]      m_len_o;
  logic [DW-1:0]        m_tx_o;
  logic                 m_busy_i;
  logic [DW-1:0]        m_rx_i;

  int n_chk = 0, n_fail = 0, cyc = 0;
  bit stuck = 0, go_d = 0;
  int busy_cnt = 0;

  spi_xfer_arbiter #(
    .NREQ(NREQ), .DW(DW), .LENW(LENW), .SSW(SSW), .GAP_CYC(GAP_CYC), .TO_CYC(TO_CYC)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .req_i(req_i), .req_ss_i(req_ss_i),
    .req_len_i(req_len_i), .req_tx_i(req_tx_i), .ack_o(ack_o), .err_o(err_o),
    .rx_o(rx_o), .m_go_o(m_go_o), .m_ss_o(m_ss_o), .m_len_o(m_len_o),
    .m_tx_o(m_tx_o), .m_busy_i(m_busy_i), .m_rx_i(m_rx_i)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // SPI master + echoing slave: busy one cycle after go for BUSY_CYC cycles,
  // RX is the inverted TX word.
  initial begin
    m_busy_i = 0;
    m_rx_i   = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        m_busy_i = 0; busy_cnt = 0; go_d = 0;
      end else begin
        if (go_d) begin
          m_busy_i = 1; busy_cnt = BUSY_CYC; m_rx_i = ~m_tx_o;
        end else if (stuck) begin
          m_busy_i = 1; busy_cnt = 0;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) m_busy_i = 0;
        end else begin
          m_busy_i = 0;
        end
        go_d = m_go_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] tx_of(input int i);
    return {32'hC0DE_0000 + 32'(i), 96'h5555_AAAA_1234_5678_9ABC_DEF0};
  endfunction

  task automatic fill_distinct();
    for (int i = 0; i < NREQ; i++) begin
      req_ss_i[i*SSW +: SSW]    = 3'(i + 4);
      req_len_i[i*LENW +: LENW] = 7'(10 + i);
      req_tx_i[i*DW +: DW]      = tx_of(i);
    end
  endtask

  task automatic wait_go(input int budget, output bit ok, output int t);
    ok = 0; t = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (m_go_o) begin ok = 1; t = cyc; break; end
    end
  endtask

  task automatic wait_ack(input int budget, output bit ok, output int t);
    ok = 0; t = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ack_o != '0) begin ok = 1; t = cyc; break; end
    end
  endtask

  task automatic run_single(input string nm, input logic [3:0] req, input logic [2:0] ss,
                            input logic [6:0] len, input logic [127:0] tx,
                            input logic [7:0] exp_ss, input logic [3:0] exp_ack);
    int t_req, t_go, t_ack;
    bit ok;
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      if (exp_ack[i]) begin
        req_ss_i[i*SSW +: SSW] = ss; req_len_i[i*LENW +: LENW] = len; req_tx_i[i*DW +: DW] = tx;
      end else begin
        req_ss_i[i*SSW +: SSW] = ~ss; req_len_i[i*LENW +: LENW] = ~len;
        req_tx_i[i*DW +: DW] = tx ^ 128'(i + 1);
      end
    end
    req_i = req;
    t_req = cyc;
    wait_go(20, ok, t_go);
    chk({nm, ".go_seen"}, 128'(ok), 128'd1);
    if (ok) begin
      chk({nm, ".go_latency"}, 128'(t_go - t_req), 128'd2);
      chk({nm, ".m_ss"}, 128'(m_ss_o), 128'(exp_ss));
      chk({nm, ".m_len"}, 128'(m_len_o), 128'(len));
      chk({nm, ".m_tx"}, m_tx_o, tx);
      @(negedge clk);
      chk({nm, ".go_one_cycle"}, 128'(m_go_o), 128'd0);
      chk({nm, ".ss_held"}, 128'(m_ss_o), 128'(exp_ss));
      wait_ack(60, ok, t_ack);
      chk({nm, ".ack_seen"}, 128'(ok), 128'd1);
      if (ok) begin
        chk({nm, ".ack"}, 128'(ack_o), 128'(exp_ack));
        chk({nm, ".rx"}, rx_o, ~tx);
        chk({nm, ".err"}, 128'(err_o), 128'd0);
        chk({nm, ".ack_latency"}, 128'(t_ack - t_go), 128'(ACK_LAT));
        chk({nm, ".ss_released"}, 128'(m_ss_o), 128'd0);
        @(negedge clk);
        chk({nm, ".ack_one_cycle"}, 128'(ack_o), 128'd0);
      end
    end
    @(posedge clk); #1;
    req_i = '0;
    repeat (3) @(posedge clk);
  endtask

  typedef struct {
    logic [3:0]   req;
    logic [2:0]   ss;
    logic [6:0]   len;
    logic [127:0] tx;
    logic [7:0]   exp_ss;
    logic [3:0]   exp_ack;
  } vec_t;

  vec_t vecs[5];
  int   order[5];

  initial begin
    bit ok;
    int t, t_go, zc, gos, e;
    logic [3:0] one;

    vecs[0] = '{4'b0001, 3'd2, 7'd8,   128'hA5,                                     8'h04, 4'b0001};
    vecs[1] = '{4'b0010, 3'd7, 7'd0,   128'hDEADBEEF_0123_4567_89AB_CDEF_F00D_CAFE, 8'h80, 4'b0010};
    vecs[2] = '{4'b0100, 3'd0, 7'd127, 128'h1,                                      8'h01, 4'b0100};
    vecs[3] = '{4'b0001, 3'd3, 7'd16,  {4{32'h5A5A_C3C3}},                          8'h08, 4'b0001};
    vecs[4] = '{4'b1000, 3'd5, 7'd32,  128'hFFFF_0000_1234_5678_8765_4321_0000_FFFF, 8'h20, 4'b1000};
    order   = '{0, 1, 2, 3, 0};

    rst_n = 0; req_i = '0; req_ss_i = '0; req_len_i = '0; req_tx_i = '0;
    repeat (3) @(negedge clk);
    chk("reset.ack", 128'(ack_o), 128'd0);
    chk("reset.err", 128'(err_o), 128'd0);
    chk("reset.rx", rx_o, 128'd0);
    chk("reset.go", 128'(m_go_o), 128'd0);
    chk("reset.ss", 128'(m_ss_o), 128'd0);
    chk("reset.len", 128'(m_len_o), 128'd0);
    chk("reset.tx", m_tx_o, 128'd0);
    rst_n = 1;
    repeat (2) @(posedge clk);

    // single transfers; the last one (requester 3) leaves the pointer at 0
    for (int v = 0; v < 5; v++)
      run_single($sformatf("vec%0d", v), vecs[v].req, vecs[v].ss, vecs[v].len, vecs[v].tx,
                 vecs[v].exp_ss, vecs[v].exp_ack);

    // all four requesting: strict rotation, slave deselected between transfers
    // for the GAP cycles plus the IDLE and ARB cycles before the next LOAD
    @(posedge clk); #1;
    fill_distinct();
    req_i = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_ack(60, ok, t);
      chk($sformatf("rr%0d.ack_seen", k), 128'(ok), 128'd1);
      if (ok) begin
        e = order[k];
        one = 4'b0001 << e;
        chk($sformatf("rr%0d.ack", k), 128'(ack_o), 128'(one));
        chk($sformatf("rr%0d.rx", k), rx_o, ~tx_of(e));
        chk($sformatf("rr%0d.ss_released", k), 128'(m_ss_o), 128'd0);
        if (k < 4) begin
          zc = 1; ok = 0;
          for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (m_go_o) begin ok = 1; break; end
            if (m_ss_o == '0) zc++;
          end
          chk($sformatf("rr%0d.next_go", k), 128'(ok), 128'd1);
          chk($sformatf("rr%0d.ss_gap", k), 128'(zc), 128'(GAP_CYC + 2));
          chk($sformatf("rr%0d.next_ss", k), 128'(m_ss_o), 128'(8'd1 << (order[k+1] + 4)));
        end
      end
    end
    @(posedge clk); #1;
    req_i = '0;
    repeat (3) @(posedge clk);

    // move pointer to 3 via requester 2, then 1001 must wrap: 3 first, then 0
    run_single("ptr3", 4'b0100, 3'd1, 7'd9, 128'h42, 8'h02, 4'b0100);
    @(posedge clk); #1;
    fill_distinct();
    req_i = 4'b1001;
    wait_ack(60, ok, t);
    chk("wrap.first_seen", 128'(ok), 128'd1);
    chk("wrap.first_ack", 128'(ack_o), 128'(4'b1000));
    chk("wrap.first_rx", rx_o, ~tx_of(3));
    @(posedge clk); #1;
    req_i = 4'b0001;
    wait_ack(60, ok, t);
    chk("wrap.second_seen", 128'(ok), 128'd1);
    chk("wrap.second_ack", 128'(ack_o), 128'(4'b0001));
    chk("wrap.second_rx", rx_o, ~tx_of(0));
    @(posedge clk); #1;
    req_i = '0;
    repeat (3) @(posedge clk);

    // one-cycle request gone before ARB: no transfer
    @(posedge clk); #1;
    req_i = 4'b0010;
    @(posedge clk); #1;
    req_i = '0;
    gos = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (m_go_o) gos++;
    end
    chk("pulse.no_go", 128'(gos), 128'd0);
    chk("pulse.ss_idle", 128'(m_ss_o), 128'd0);

    // requester drops after grant: ack still delivered with its data
    @(posedge clk); #1;
    fill_distinct();
    req_i = 4'b0010;
    wait_go(20, ok, t_go);
    chk("drop.go_seen", 128'(ok), 128'd1);
    @(posedge clk); #1;
    req_i = '0;
    wait_ack(60, ok, t);
    chk("drop.ack_seen", 128'(ok), 128'd1);
    chk("drop.ack", 128'(ack_o), 128'(4'b0010));
    chk("drop.rx", rx_o, ~tx_of(1));
    chk("drop.ack_latency", 128'(t - t_go), 128'(ACK_LAT));
    repeat (4) @(posedge clk);

    // reset during WAIT; afterwards pointer restarts at 0 (1010 -> requester 1)
    @(posedge clk); #1;
    fill_distinct();
    req_i = 4'b0100;
    wait_go(20, ok, t_go);
    chk("rst.go_seen", 128'(ok), 128'd1);
    repeat (5) @(negedge clk);
    chk("rst.ss_before", 128'(m_ss_o), 128'(8'h40));
    #2 rst_n = 0;
    #1;
    chk("rst.ss", 128'(m_ss_o), 128'd0);
    chk("rst.go", 128'(m_go_o), 128'd0);
    chk("rst.ack", 128'(ack_o), 128'd0);
    chk("rst.tx", m_tx_o, 128'd0);
    req_i = '0;
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    fill_distinct();
    req_i = 4'b1010;
    wait_ack(60, ok, t);
    chk("rst.resume_seen", 128'(ok), 128'd1);
    chk("rst.resume_ack", 128'(ack_o), 128'(4'b0010));
    chk("rst.resume_rx", rx_o, ~tx_of(1));
    @(posedge clk); #1;
    req_i = '0;
    repeat (3) @(posedge clk);

`ifdef SPI_ARB_TIMEOUT_EN
    // busy stuck high: watchdog after TO_CYC LOAD+WAIT cycles, ack the cycle after RESP
    @(posedge clk); #1;
    fill_distinct();
    stuck = 1;
    req_i = 4'b0001;
    wait_go(20, ok, t_go);
    chk("to.go_seen", 128'(ok), 128'd1);
    wait_ack(150, ok, t);
    chk("to.ack_seen", 128'(ok), 128'd1);
    chk("to.ack", 128'(ack_o), 128'(4'b0001));
    chk("to.err", 128'(err_o), 128'd1);
    chk("to.rx", rx_o, 128'd0);
    chk("to.latency", 128'(t - t_go), 128'(TO_CYC + 1));
    @(posedge clk); #1;
    req_i = '0;
    stuck = 0;
    repeat (4) @(posedge clk);
`endif

    run_single("final", 4'b0100, 3'd6, 7'd24, 128'h0BAD_F00D, 8'h40, 4'b0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
